vga_ctrl: RTL and testbench

VGA_CTRL -- requirements
Module: vga_ctrl

---
 rtl/vga_ctrl.sv | 79 +++++++
 tb/tb_vga_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator: free-running beam counters, sync decode, and a
// pixel request port that runs one clock ahead of the visible beam.
module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0     = H_SYNC + H_BACK;
  localparam int VA0     = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] HA_FIRST  = 10'(HA0);
  localparam logic [9:0] HA_LAST   = 10'(HA0 + H_ACTIVE - 1);
  localparam logic [9:0] REQ_FIRST = 10'(HA0 - 1);
  localparam logic [9:0] REQ_LAST  = 10'(HA0 + H_ACTIVE - 2);
  localparam logic [9:0] VA_FIRST  = 10'(VA0);
  localparam logic [9:0] VA_LAST   = 10'(VA0 + V_ACTIVE - 1);
  localparam logic [9:0] NO_REQ    = 10'h3FF;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_active;
  logic       h_req;
  logic       v_active;
  logic       pix_req;

  // Reset takes priority over the end-of-frame wrap so a restart always begins at 0,0.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // The request window is the active window shifted one clock earlier, matching
  // the single register stage inside the image generator.
  always_comb begin
    h_active = (h_cnt >= HA_FIRST) && (h_cnt <= HA_LAST);
    h_req    = (h_cnt >= REQ_FIRST) && (h_cnt <= REQ_LAST);
    v_active = (v_cnt >= VA_FIRST) && (v_cnt <= VA_LAST);
    pix_req  = h_req && v_active;

    hsync       = (h_cnt >= H_SYNC_W);
    vsync       = (v_cnt >= V_SYNC_W);
    rgb_valid   = h_active && v_active;
    frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    pix_x       = pix_req ? (h_cnt - REQ_FIRST) : NO_REQ;
    pix_y       = pix_req ? (v_cnt - VA_FIRST) : NO_REQ;
    rgb         = rgb_valid ? pix_data : 16'h0000;
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a shrunken-timing instance with random resets and a default
// 640x480 instance, both compared every clock against a beam-position model.
module tb_vga_ctrl;

  localparam int S_HS = 4, S_HB = 3, S_HA = 10, S_HF = 2;
  localparam int S_VS = 2, S_VB = 2, S_VA = 5,  S_VF = 3;
  localparam int S_FRAME = (S_HS + S_HB + S_HA + S_HF) * (S_VS + S_VB + S_VA + S_VF);
  localparam int D_FRAME = 800 * 525;
  localparam int N_CYCLES = 32000;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb;
  } vga_t;

  logic        clk = 1'b0;
  logic        rst_s, rst_d;
  logic [15:0] pix_data_s, pix_data_d;
  logic [9:0]  pix_x_s, pix_y_s, pix_x_d, pix_y_d;
  logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
  logic        hsync_d, vsync_d, rgb_valid_d, frame_start_d;
  logic [15:0] rgb_s, rgb_d;

  int          errors = 0;
  int          checks = 0;
  int          n_s, n_d;
  int          hold_s = 0;
  logic [15:0] salt;

  vga_ctrl #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_ACTIVE(S_HA), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_ACTIVE(S_VA), .V_FRONT(S_VF)
  ) dut_small (
    .clk(clk), .rst(rst_s), .pix_data(pix_data_s), .pix_x(pix_x_s), .pix_y(pix_y_s),
    .hsync(hsync_s), .vsync(vsync_s), .rgb(rgb_s), .rgb_valid(rgb_valid_s),
    .frame_start(frame_start_s)
  );

  vga_ctrl dut_default (
    .clk(clk), .rst(rst_d), .pix_data(pix_data_d), .pix_x(pix_x_d), .pix_y(pix_y_d),
    .hsync(hsync_d), .vsync(vsync_d), .rgb(rgb_d), .rgb_valid(rgb_valid_d),
    .frame_start(frame_start_d)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pixelValue(input logic [9:0] x, input logic [9:0] y,
                                             input logic [15:0] s);
    return {y[4:0], x[5:0], y[9:5]} ^ s;
  endfunction

  // Expected outputs from the number of clocks elapsed since the frame origin.
  function automatic vga_t model(input int hs, input int hb, input int ha, input int hf,
                                 input int vs, input int vb, input int va, input int vf,
                                 input int n, input logic [15:0] s);
    vga_t e;
    int ht, h, v, ha0, va0;
    bit row_on, req;
    ht  = hs + hb + ha + hf;
    h   = n % ht;
    v   = n / ht;
    ha0 = hs + hb;
    va0 = vs + vb;
    row_on  = (v >= va0) && (v < va0 + va);
    req     = row_on && (h >= ha0 - 1) && (h < ha0 + ha - 1);
    e.hsync = !(h < hs);
    e.vsync = !(v < vs);
    e.valid = row_on && (h >= ha0) && (h < ha0 + ha);
    e.fs    = (n == 0);
    e.x     = req ? 10'(h - ha0 + 1) : 10'h3FF;
    e.y     = req ? 10'(v - va0) : 10'h3FF;
    e.rgb   = e.valid ? pixelValue(10'(h - ha0), 10'(v - va0), s) : 16'h0000;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    vga_t es, ed;
    es = model(S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF, n_s, salt);
    ed = model(96, 48, 640, 16, 2, 33, 480, 10, n_d, salt);
    checkOutput("s_hsync", 32'(hsync_s), 32'(es.hsync));
    checkOutput("s_vsync", 32'(vsync_s), 32'(es.vsync));
    checkOutput("s_valid", 32'(rgb_valid_s), 32'(es.valid));
    checkOutput("s_frame_start", 32'(frame_start_s), 32'(es.fs));
    checkOutput("s_pix_x", 32'(pix_x_s), 32'(es.x));
    checkOutput("s_pix_y", 32'(pix_y_s), 32'(es.y));
    checkOutput("s_rgb", 32'(rgb_s), 32'(es.rgb));
    checkOutput("d_hsync", 32'(hsync_d), 32'(ed.hsync));
    checkOutput("d_vsync", 32'(vsync_d), 32'(ed.vsync));
    checkOutput("d_valid", 32'(rgb_valid_d), 32'(ed.valid));
    checkOutput("d_frame_start", 32'(frame_start_d), 32'(ed.fs));
    checkOutput("d_pix_x", 32'(pix_x_d), 32'(ed.x));
    checkOutput("d_pix_y", 32'(pix_y_d), 32'(ed.y));
    checkOutput("d_rgb", 32'(rgb_d), 32'(ed.rgb));
  endtask

  // Inputs change on the falling edge; pix_data answers this cycle's request at the next rise.
  task automatic applyStimulus(input int cyc);
    if (hold_s > 0) begin
      rst_s = 1'b1;
      hold_s--;
    end else if ($urandom_range(0, 399) == 0) begin
      rst_s  = 1'b1;
      hold_s = int'($urandom_range(0, 2));
    end else begin
      rst_s = 1'b0;
    end
    rst_d = (cyc >= 1300) && (cyc < 1303);
    pix_data_s = pixelValue(pix_x_s, pix_y_s, salt);
    pix_data_d = pixelValue(pix_x_d, pix_y_d, salt);
    n_s = rst_s ? 0 : (n_s + 1) % S_FRAME;
    n_d = rst_d ? 0 : (n_d + 1) % D_FRAME;
    @(negedge clk);
  endtask

  initial begin
    salt       = 16'($urandom);
    rst_s      = 1'b1;
    rst_d      = 1'b1;
    pix_data_s = 16'h0000;
    pix_data_d = 16'h0000;
    @(negedge clk);
    n_s = 0;
    n_d = 0;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      checkAll();
      applyStimulus(cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
